// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage sitting directly behind the program counter. Issues
// read requests at the current PC, captures returned words into the IF/ID
// pipeline register and uses a one-entry skid buffer to absorb a decode stall
// that arrives while a word is already in flight. Drives the PC enable so the
// PC advances only on an accepted fetch or a redirect.
//
// State   | Meaning
// --------+-----------------------------------------------------------
// FETCH   | request outstanding at pc_addr
// STALLED | skid buffer holds one word, no request issued
// HALTED  | terminal, left only through reset
//
// Ports
//   CLK          in   1   clock, rising edge
//   nRST         in   1   asynchronous active-low reset
//   pc_addr      in   32  current PC value
//   pcenable     out  1   PC update enable (combinational)
//   iREN         out  1   instruction read request (combinational)
//   iaddr        out  32  request address, always pc_addr
//   ihit         in   1   iload valid this cycle
//   iload        in   32  instruction word from memory
//   stall        in   1   decode cannot consume IF/ID this cycle
//   flush        in   1   redirect, kill younger instructions
//   halt         in   1   decode holds a halt instruction
//   ifid_valid   out  1   IF/ID holds a live instruction
//   ifid_instr   out  32  fetched instruction
//   ifid_pc      out  32  address of ifid_instr
//   ifid_npc     out  32  ifid_pc + 4
//   fetch_count  out  32  accepted-fetch counter, wraps
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pc_addr,
    output logic        pcenable,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        stall,
    input  logic        flush,
    input  logic        halt,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_npc,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        STALLED = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        accept;

    // The memory side samples iREN/iaddr combinationally, so these cannot be
    // registered without adding a cycle of fetch latency.
    assign iREN     = (state == FETCH);
    assign iaddr    = pc_addr;
    assign accept   = iREN & ihit & ~flush & ~halt;
    assign pcenable = accept | (flush & (state != HALTED));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= FETCH;
            ifid_valid  <= 1'b0;
            ifid_instr  <= NOP_INSTR;
            ifid_pc     <= 32'h0;
            ifid_npc    <= 32'h0;
            skid_instr  <= 32'h0;
            skid_pc     <= 32'h0;
            fetch_count <= 32'h0;
        end else begin
            case (state)
                FETCH: begin
                    if (flush) begin
                        // Returned data this cycle belongs to the wrong path.
                        ifid_valid <= 1'b0;
                        ifid_instr <= NOP_INSTR;
                    end else if (halt) begin
                        state <= HALTED;
                    end else if (accept) begin
                        fetch_count <= fetch_count + 32'd1;
                        if (!ifid_valid || !stall) begin
                            ifid_valid <= 1'b1;
                            ifid_instr <= iload;
                            ifid_pc    <= pc_addr;
                            ifid_npc   <= pc_addr + 32'd4;
                        end else begin
                            // Word was already requested before decode stalled;
                            // park it rather than drop it.
                            skid_instr <= iload;
                            skid_pc    <= pc_addr;
                            state      <= STALLED;
                        end
                    end else if (ifid_valid && !stall) begin
                        ifid_valid <= 1'b0;
                    end
                end

                STALLED: begin
                    if (flush) begin
                        ifid_valid <= 1'b0;
                        ifid_instr <= NOP_INSTR;
                        state      <= FETCH;
                    end else if (halt) begin
                        state <= HALTED;
                    end else if (!stall) begin
                        ifid_valid <= 1'b1;
                        ifid_instr <= skid_instr;
                        ifid_pc    <= skid_pc;
                        ifid_npc   <= skid_pc + 32'd4;
                        state      <= FETCH;
                    end
                end

                HALTED: begin
                    // Everything frozen until reset.
                end

                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] pc_addr = 32'h0;
    logic        pcenable;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit = 1'b0;
    logic [31:0] iload = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        halt = 1'b0;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_npc;
    logic [31:0] fetch_count;

    fetch_unit #(.NOP_INSTR(NOP)) dut (
        .CLK(CLK), .nRST(nRST), .pc_addr(pc_addr), .pcenable(pcenable),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .stall(stall), .flush(flush), .halt(halt),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .ifid_npc(ifid_npc), .fetch_count(fetch_count)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Redirect target supplied with flush; PC model owned by the compare process.
    logic [31:0] target = 32'h0;
    logic [31:0] pc_next = 32'h0;
    logic        preload = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic [31:0] instr; logic [31:0] pc; } word_t;
    word_t       skid_q[$];
    bit          m_halted;
    bit          m_valid;
    logic [31:0] m_instr, m_pc, m_npc, m_count;

    always @(negedge CLK) begin
        bit accepted;
        bit pcen;
        if (!nRST) begin
            skid_q.delete();
            m_halted = 0; m_valid = 0; m_instr = NOP;
            m_pc = 0; m_npc = 0; m_count = 0;
            pc_next = 32'h0;
        end
        if (preload) m_count = 32'hFFFF_FFFF;

        accepted = !m_halted && skid_q.size() == 0 && ihit && !flush && !halt;
        pcen     = accepted || (flush && !m_halted);

        chk("iREN", {31'b0, iREN}, {31'b0, (!m_halted && skid_q.size() == 0)});
        chk("pcenable", {31'b0, pcenable}, {31'b0, pcen});
        chk("iaddr", iaddr, pc_addr);
        chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_pc", ifid_pc, m_pc);
        chk("ifid_npc", ifid_npc, m_npc);
        chk("fetch_count", fetch_count, m_count);

        if (nRST && !m_halted) begin
            if (flush) begin
                m_valid = 0; m_instr = NOP; skid_q.delete();
            end else if (halt) begin
                m_halted = 1;
            end else if (skid_q.size() != 0) begin
                if (!stall) begin
                    m_valid = 1; m_instr = skid_q[0].instr;
                    m_pc = skid_q[0].pc; m_npc = skid_q[0].pc + 32'd4;
                    skid_q.delete();
                end
            end else if (accepted) begin
                if (!m_valid || !stall) begin
                    m_valid = 1; m_instr = iload; m_pc = pc_addr; m_npc = pc_addr + 32'd4;
                end else begin
                    skid_q.push_back('{iload, pc_addr});
                end
            end else if (m_valid && !stall) begin
                m_valid = 0;
            end
            if (accepted) m_count = m_count + 32'd1;
            if (flush) pc_next = target;
            else if (pcen) pc_next = pc_addr + 32'd4;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic h, input logic [31:0] w, input logic s,
                         input logic f, input logic hl, input logic [31:0] tgt);
        ihit = h; iload = w; stall = s; flush = f; halt = hl; target = tgt;
        pc_addr = pc_next;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        nRST = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        chk("rst_iREN", {31'b0, iREN}, 32'd1);
        chk("rst_pcenable", {31'b0, pcenable}, 32'd0);
        chk("rst_instr", ifid_instr, NOP);
        chk("rst_pc", ifid_pc, 32'h0);
        chk("rst_count", fetch_count, 32'h0);

        // Streaming
        drive(1, 32'hA000_0000, 0, 0, 0, 0);
        chk("stream_pcen0", {31'b0, pcenable}, 32'd1);
        tick();
        chk("stream_pc0", ifid_pc, 32'h0);
        chk("stream_npc0", ifid_npc, 32'h4);
        drive(1, 32'hA000_0004, 0, 0, 0, 0);
        chk("stream_pcen1", {31'b0, pcenable}, 32'd1);
        tick();
        chk("stream_pc1", ifid_pc, 32'h4);
        drive(1, 32'hA000_0008, 0, 0, 0, 0);
        tick();
        chk("stream_pc2", ifid_pc, 32'h8);
        chk("stream_npc2", ifid_npc, 32'hC);
        chk("stream_count", fetch_count, 32'd3);

        // Wait states at PC 0x10
        drive(1, 32'hA000_000C, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'hDEAD_BEEF, 0, 0, 0, 0);
            chk("wait_pcen", {31'b0, pcenable}, 32'd0);
            tick();
        end
        drive(1, 32'h2002_0005, 0, 0, 0, 0);
        chk("wait_addr", iaddr, 32'h10);
        chk("wait_pcen_hit", {31'b0, pcenable}, 32'd1);
        tick();
        chk("wait_instr", ifid_instr, 32'h2002_0005);
        chk("wait_pc", ifid_pc, 32'h10);

        // Stall and skid
        drive(0, 0, 0, 1, 0, 32'h1C);
        tick();
        drive(1, 32'hB000_001C, 0, 0, 0, 0);
        tick();
        drive(1, 32'hB000_0020, 1, 0, 0, 0);
        chk("skid_addr", iaddr, 32'h20);
        chk("skid_pcen", {31'b0, pcenable}, 32'd1);
        tick();
        drive(0, 0, 1, 0, 0, 0);
        chk("skid_iREN", {31'b0, iREN}, 32'd0);
        chk("skid_hold_pc", ifid_pc, 32'h1C);
        chk("skid_hold_instr", ifid_instr, 32'hB000_001C);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("skid_out_pc", ifid_pc, 32'h20);
        chk("skid_out_instr", ifid_instr, 32'hB000_0020);
        chk("skid_out_iREN", {31'b0, iREN}, 32'd1);

        // Flush with ihit in FETCH
        drive(1, 32'hCCCC_0000, 0, 1, 0, 32'h40);
        chk("flushF_pcen", {31'b0, pcenable}, 32'd1);
        tick();
        chk("flushF_valid", {31'b0, ifid_valid}, 32'd0);
        chk("flushF_instr", ifid_instr, NOP);
        chk("flushF_count", fetch_count, 32'd7);

        // Flush while STALLED
        drive(1, 32'hC000_0040, 0, 0, 0, 0);
        tick();
        drive(1, 32'hC000_0044, 1, 0, 0, 0);
        tick();
        drive(1, 32'hCCCC_0001, 1, 1, 0, 32'h80);
        chk("flushS_iREN", {31'b0, iREN}, 32'd0);
        chk("flushS_pcen", {31'b0, pcenable}, 32'd1);
        tick();
        chk("flushS_valid", {31'b0, ifid_valid}, 32'd0);
        chk("flushS_instr", ifid_instr, NOP);
        chk("flushS_count", fetch_count, 32'd9);
        chk("flushS_iREN_after", {31'b0, iREN}, 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("flushS_skid_empty", {31'b0, ifid_valid}, 32'd0);

        // Halt
        drive(1, 32'hD000_0080, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'hEEEE_0000, 0, 1, 0, 32'h100);
            chk("halt_iREN", {31'b0, iREN}, 32'd0);
            chk("halt_pcen", {31'b0, pcenable}, 32'd0);
            tick();
            chk("halt_count", fetch_count, 32'd10);
        end
        drive(0, 0, 0, 0, 0, 0);
        nRST = 1'b0;
        #1;
        chk("halt_rst_valid", {31'b0, ifid_valid}, 32'd0);
        chk("halt_rst_count", fetch_count, 32'd0);
        chk("halt_rst_iREN", {31'b0, iREN}, 32'd1);
        tick();
        nRST = 1'b1;

        // Randomized traffic, including async resets mid-request
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 149) == 0),
                  {$urandom_range(0, 1023), 2'b00});
            if ($urandom_range(0, 199) == 0) begin
                nRST = 1'b0;
                tick();
                nRST = 1'b1;
            end else begin
                tick();
            end
        end

        // Counter wrap
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        force dut.fetch_count = 32'hFFFF_FFFF;
        preload = 1'b1;
        tick();
        preload = 1'b0;
        release dut.fetch_count;
        drive(1, 32'hF000_0000, 0, 0, 0, 0);
        tick();
        chk("wrap_count", fetch_count, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
